// File: rtl/floor_request_scheduler_pkg.sv
// Shared definitions for the 3-floor elevator scheduler: floor codes,
// call/led bit order, FSM state encoding and the SCAN helper functions.
package floor_request_scheduler_pkg;

   localparam logic [1:0] ST_FLOOR = 2'b00;
   localparam logic [1:0] ND_FLOOR = 2'b01;
   localparam logic [1:0] RD_FLOOR = 2'b10;
   localparam int         N_FLOORS = 3;

   // Bit positions inside call_btn / pending / leds
   localparam int ST_BIT = 0;
   localparam int ND_BIT = 1;
   localparam int RD_BIT = 2;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MOVE      = 3'd1,
      S_DOOR_REQ  = 3'd2,
      S_DOOR_WAIT = 3'd3,
      S_EMERG     = 3'd4
   } state_t;

   // One-hot mask of a floor code in call/pending bit order
   function automatic logic [N_FLOORS-1:0] floor_mask(input logic [1:0] f);
      logic [N_FLOORS-1:0] m;
      m = '0;
      case (f)
         ST_FLOOR: m[ST_BIT] = 1'b1;
         ND_FLOOR: m[ND_BIT] = 1'b1;
         RD_FLOOR: m[RD_BIT] = 1'b1;
         default:  m = '0;
      endcase
      return m;
   endfunction

   // Any pending call strictly beyond floor f in the given direction
   function automatic logic pending_ahead(input logic [N_FLOORS-1:0] pend,
                                          input logic [1:0] f, input logic up);
      logic hit;
      hit = 1'b0;
      if (up) begin
         if (f == ST_FLOOR)      hit = pend[ND_BIT] | pend[RD_BIT];
         else if (f == ND_FLOOR) hit = pend[RD_BIT];
      end else begin
         if (f == RD_FLOOR)      hit = pend[ND_BIT] | pend[ST_BIT];
         else if (f == ND_FLOOR) hit = pend[ST_BIT];
      end
      return hit;
   endfunction

   // Direction is pinned at the end floors so SCAN never aims past them
   function automatic logic forced_dir(input logic [1:0] f, input logic up);
      logic d;
      d = up;
      if (f == ST_FLOOR)      d = 1'b1;
      else if (f == RD_FLOOR) d = 1'b0;
      return d;
   endfunction

   // Neighbouring floor in the given direction, saturating at the ends
   function automatic logic [1:0] step_floor(input logic [1:0] f, input logic up);
      logic [1:0] r;
      r = f;
      if (up && f != RD_FLOOR)       r = f + 2'b01;
      else if (!up && f != ST_FLOOR) r = f - 2'b01;
      return r;
   endfunction

endpackage

// File: rtl/floor_request_scheduler_travel_timer.sv
// Inter-floor travel counter. Counts 0..TRAVEL_CYCLES-1 while run is high,
// holds while freeze is high, and pulses done on the terminal count.
module travel_timer #(
   parameter int TRAVEL_CYCLES = 8,
   parameter int CNT_W         = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic freeze,
   input  logic clear,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TRAVEL_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, freeze holds, terminal count wraps to 0
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run && !freeze) begin
         if (cnt_q == LAST) cnt_d = '0;
         else               cnt_d = cnt_q + 1'b1;
      end
   end

   assign done = run && !freeze && !clear && (cnt_q == LAST);

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/floor_request_scheduler.sv
// Elevator controller: latches calls, picks the next floor with SCAN, times
// travel via travel_timer and runs the door req/ack/done handshake.
module floor_request_scheduler
   import floor_request_scheduler_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 8,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] call_btn,
   input  logic       sos_mode,
   input  logic       door_ack,
   input  logic       door_done,
   output logic [1:0] floor,
   output logic [1:0] next_floor,
   output logic       is_moving,
   output logic       dir_up,
   output logic       door_req,
   output logic [1:0] open_when,
   output logic       st_led,
   output logic       nd_led,
   output logic       rd_led
);

   state_t               state_q, state_d;
   logic [N_FLOORS-1:0]  pending_q, pending_d;
   logic [1:0]           floor_q, floor_d;
   logic [1:0]           next_floor_q, next_floor_d;
   logic [1:0]           open_when_q, open_when_d;
   logic                 is_moving_q, is_moving_d;
   logic                 dir_up_q, dir_up_d;
   logic                 door_req_q, door_req_d;
   logic [N_FLOORS-1:0]  call_eff;
   logic                 dir_arr;
   logic                 travel_done;

   travel_timer #(
      .TRAVEL_CYCLES (TRAVEL_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (state_q == S_MOVE),
      .freeze (sos_mode),
      .clear  (state_q == S_IDLE),
      .done   (travel_done)
   );

   // Next-state, pending calls and registered outputs of the scheduler FSM
   always_comb begin
      state_d      = state_q;
      floor_d      = floor_q;
      next_floor_d = next_floor_q;
      open_when_d  = open_when_q;
      is_moving_d  = is_moving_q;
      dir_up_d     = dir_up_q;
      door_req_d   = door_req_q;
      dir_arr      = forced_dir(next_floor_q, dir_up_q);

      // A call for the floor whose door is being cycled is already being served
      call_eff = call_btn;
      if (state_q == S_DOOR_REQ || state_q == S_DOOR_WAIT)
         call_eff = call_btn & ~floor_mask(floor_q);
      pending_d = pending_q | call_eff;

      if (sos_mode) begin
         state_d     = S_EMERG;
         is_moving_d = 1'b0;
         door_req_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if ((pending_q & floor_mask(floor_q)) != '0) begin
                  state_d     = S_DOOR_REQ;
                  door_req_d  = 1'b1;
                  open_when_d = floor_q;
               end else if (pending_ahead(pending_q, floor_q, dir_up_q)) begin
                  state_d      = S_MOVE;
                  is_moving_d  = 1'b1;
                  next_floor_d = step_floor(floor_q, dir_up_q);
               end else if (pending_ahead(pending_q, floor_q, !dir_up_q)) begin
                  state_d      = S_MOVE;
                  is_moving_d  = 1'b1;
                  dir_up_d     = !dir_up_q;
                  next_floor_d = step_floor(floor_q, !dir_up_q);
               end
            end
            S_MOVE: begin
               if (travel_done) begin
                  floor_d  = next_floor_q;
                  dir_up_d = dir_arr;
                  if ((pending_q & floor_mask(next_floor_q)) != '0) begin
                     state_d     = S_DOOR_REQ;
                     is_moving_d = 1'b0;
                     door_req_d  = 1'b1;
                     open_when_d = next_floor_q;
                  end else if (pending_ahead(pending_q, next_floor_q, dir_arr)) begin
                     next_floor_d = step_floor(next_floor_q, dir_arr);
                  end else begin
                     state_d     = S_IDLE;
                     is_moving_d = 1'b0;
                  end
               end
            end
            S_DOOR_REQ: begin
               if (door_ack) begin
                  pending_d  = pending_d & ~floor_mask(floor_q);
                  door_req_d = 1'b0;
                  state_d    = door_done ? S_IDLE : S_DOOR_WAIT;
               end
            end
            S_DOOR_WAIT: begin
               if (door_done) state_d = S_IDLE;
            end
            S_EMERG: begin
               // An interrupted move resumes; an interrupted door cycle is dropped
               if (next_floor_q != floor_q) begin
                  state_d     = S_MOVE;
                  is_moving_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         floor_q      <= ST_FLOOR;
         next_floor_q <= ST_FLOOR;
         open_when_q  <= ST_FLOOR;
         is_moving_q  <= 1'b0;
         dir_up_q     <= 1'b1;
         door_req_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         floor_q      <= floor_d;
         next_floor_q <= next_floor_d;
         open_when_q  <= open_when_d;
         is_moving_q  <= is_moving_d;
         dir_up_q     <= dir_up_d;
         door_req_q   <= door_req_d;
      end
   end

   assign floor      = floor_q;
   assign next_floor = next_floor_q;
   assign open_when  = open_when_q;
   assign is_moving  = is_moving_q;
   assign dir_up     = dir_up_q;
   assign door_req   = door_req_q;
   assign st_led     = pending_q[ST_BIT];
   assign nd_led     = pending_q[ND_BIT];
   assign rd_led     = pending_q[RD_BIT];

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: directed scenarios plus randomized call
// sets, with door cycles checked by a scoreboard against a SCAN order model.
module tb_floor_request_scheduler;

   localparam int TC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] call_btn;
   logic       sos_mode;
   logic       door_ack;
   logic       door_done;
   logic [1:0] floor;
   logic [1:0] next_floor;
   logic       is_moving;
   logic       dir_up;
   logic       door_req;
   logic [1:0] open_when;
   logic       st_led;
   logic       nd_led;
   logic       rd_led;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   int ack_dly   = 0;
   int done_dly  = 1;
   bit same_cyc  = 0;
   bit resp_busy = 0;

   floor_request_scheduler #(.TRAVEL_CYCLES(TC), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .call_btn   (call_btn),
      .sos_mode   (sos_mode),
      .door_ack   (door_ack),
      .door_done  (door_done),
      .floor      (floor),
      .next_floor (next_floor),
      .is_moving  (is_moving),
      .dir_up     (dir_up),
      .door_req   (door_req),
      .open_when  (open_when),
      .st_led     (st_led),
      .nd_led     (nd_led),
      .rd_led     (rd_led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [2:0] c);
      call_btn = c;
      @(negedge clk);
      call_btn = 3'b000;
   endtask

   task automatic wait_moving(input string nm);
      int t;
      t = 0;
      while (!is_moving && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_move_start"}, is_moving, 1);
   endtask

   task automatic wait_req(input logic lvl, input string nm);
      int t;
      t = 0;
      while (door_req !== lvl && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_door_req_level"}, door_req, lvl);
   endtask

   task automatic wait_idle(input string nm);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || resp_busy || door_req || is_moving) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_idle_timeout: queue=%0d busy=%0d req=%0d moving=%0d required all 0",
                  nm, exp_q.size(), resp_busy, door_req, is_moving);
      end
      tick(2);
   endtask

   // Monitor: every new door request must match the next expected floor
   initial begin : monitor
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && door_req && !prev) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_door: got open_when=%0d required no request", open_when);
            end else begin
               chk("door_floor", open_when, exp_q.pop_front());
            end
            chk("door_req_while_stopped", is_moving, 0);
         end
         prev = door_req;
      end
   end

   // Door block model: acknowledges a request, then reports the cycle done
   initial begin : responder
      door_ack  = 1'b0;
      door_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && door_req) begin
            resp_busy = 1'b1;
            repeat (ack_dly) @(negedge clk);
            door_ack  = 1'b1;
            door_done = same_cyc;
            @(negedge clk);
            door_ack  = 1'b0;
            door_done = 1'b0;
            if (!same_cyc) begin
               repeat (done_dly) @(negedge clk);
               door_done = 1'b1;
               @(negedge clk);
               door_done = 1'b0;
            end
            resp_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int          m_floor;
      bit          m_dir;
      logic [2:0]  c;

      rst      = 1'b1;
      call_btn = 3'b000;
      sos_mode = 1'b0;
      tick(2);
      rst = 1'b0;

      chk("rst_floor", floor, 0);
      chk("rst_next_floor", next_floor, 0);
      chk("rst_open_when", open_when, 0);
      chk("rst_is_moving", is_moving, 0);
      chk("rst_dir_up", dir_up, 1);
      chk("rst_door_req", door_req, 0);
      chk("rst_leds", {rd_led, nd_led, st_led}, 0);

      // Reset in the middle of a move
      press(3'b100);
      wait_moving("t1");
      tick(2);
      #2 rst = 1'b1;
      #1;
      chk("t1_floor", floor, 0);
      chk("t1_next_floor", next_floor, 0);
      chk("t1_is_moving", is_moving, 0);
      chk("t1_dir_up", dir_up, 1);
      chk("t1_door_req", door_req, 0);
      chk("t1_rd_led", rd_led, 0);
      @(negedge clk);
      rst = 1'b0;
      tick(3 * TC);
      chk("t1_stays_idle", is_moving, 0);
      chk("t1_stays_st", floor, 0);

      // ST to RD, passing ND
      ack_dly  = 1;
      done_dly = 2;
      exp_q.push_back(2);
      press(3'b100);
      chk("t2_rd_led_next_cycle", rd_led, 1);
      wait_moving("t2");
      chk("t2_next_floor", next_floor, 1);
      tick(TC);
      chk("t2_floor_nd", floor, 1);
      chk("t2_next_rd", next_floor, 2);
      chk("t2_moving_through", is_moving, 1);
      tick(TC);
      chk("t2_floor_rd", floor, 2);
      chk("t2_stopped", is_moving, 0);
      chk("t2_door_req", door_req, 1);
      chk("t2_open_when", open_when, 2);
      wait_req(1'b0, "t2");
      chk("t2_rd_led_cleared", rd_led, 0);
      wait_idle("t2");
      chk("t2_dir_at_rd", dir_up, 0);

      // Door cycle at the current floor, ack and done together
      exp_q.push_back(1);
      press(3'b010);
      wait_idle("t3a");
      chk("t3_at_nd", floor, 1);
      same_cyc = 1;
      ack_dly  = 0;
      exp_q.push_back(1);
      press(3'b010);
      tick(1);
      chk("t3_door_req", door_req, 1);
      chk("t3_open_when", open_when, 1);
      chk("t3_no_move", is_moving, 0);
      tick(1);
      chk("t3_req_dropped", door_req, 0);
      chk("t3_nd_led", nd_led, 0);
      tick(1);
      chk("t3_not_reissued", door_req, 0);
      chk("t3_still_no_move", is_moving, 0);
      same_cyc = 0;
      wait_idle("t3b");

      // ND to RD upward with a call behind: RD first, then ST
      exp_q.push_back(2);
      exp_q.push_back(0);
      press(3'b100);
      wait_moving("t4");
      chk("t4_dir_up", dir_up, 1);
      chk("t4_next_rd", next_floor, 2);
      tick(1);
      press(3'b101);
      wait_req(1'b1, "t4");
      chk("t4_served_rd", floor, 2);
      chk("t4_dir_down", dir_up, 0);
      chk("t4_st_led", st_led, 1);
      wait_moving("t4b");
      chk("t4_leaving_rd", floor, 2);
      tick(2 * TC);
      chk("t4_at_st", floor, 0);
      chk("t4_door_at_st", door_req, 1);
      wait_idle("t4");

      // Freeze mid-move
      exp_q.push_back(1);
      press(3'b010);
      wait_moving("t5");
      tick(2);
      sos_mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t5_frozen_moving", is_moving, 0);
         chk("t5_frozen_floor", floor, 0);
         chk("t5_frozen_next", next_floor, 1);
      end
      sos_mode = 1'b0;
      tick(1);
      chk("t5_resume", is_moving, 1);
      chk("t5_resume_floor", floor, 0);
      tick(1);
      chk("t5_one_left", floor, 0);
      tick(1);
      chk("t5_arrived", floor, 1);
      chk("t5_door", door_req, 1);
      wait_idle("t5");

      // Freeze during the door-open phase, new call latched meanwhile
      ack_dly  = 0;
      done_dly = 8;
      exp_q.push_back(1);
      press(3'b010);
      wait_req(1'b1, "t6a");
      wait_req(1'b0, "t6b");
      sos_mode = 1'b1;
      exp_q.push_back(2);
      press(3'b100);
      chk("t6_call_latched", rd_led, 1);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("t6_no_door_req", door_req, 0);
         chk("t6_nd_led", nd_led, 0);
         chk("t6_no_move", is_moving, 0);
      end
      sos_mode = 1'b0;
      tick(1);
      chk("t6_release_idle", is_moving, 0);
      chk("t6_release_no_req", door_req, 0);
      tick(1);
      chk("t6_serve_new_call", is_moving, 1);
      wait_idle("t6");
      done_dly = 1;

      // Randomized call sets against a SCAN ordering model
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      m_floor = 0;
      m_dir   = 1'b1;
      for (int it = 0; it < 30; it++) begin
         bit d;
         bit any_behind;
         int last;
         ack_dly  = $urandom_range(0, 2);
         done_dly = $urandom_range(0, 3);
         same_cyc = ($urandom_range(0, 3) == 0);
         c = 3'($urandom_range(1, 7));

         d = (m_floor == 0) ? 1'b1 : (m_floor == 2) ? 1'b0 : m_dir;
         any_behind = 1'b0;
         last = m_floor;
         if (c[m_floor]) exp_q.push_back(m_floor);
         if (d) begin
            for (int f = m_floor + 1; f <= 2; f++)
               if (c[f]) begin exp_q.push_back(f); last = f; end
            for (int f = m_floor - 1; f >= 0; f--)
               if (c[f]) begin exp_q.push_back(f); last = f; any_behind = 1'b1; end
         end else begin
            for (int f = m_floor - 1; f >= 0; f--)
               if (c[f]) begin exp_q.push_back(f); last = f; end
            for (int f = m_floor + 1; f <= 2; f++)
               if (c[f]) begin exp_q.push_back(f); last = f; any_behind = 1'b1; end
         end
         m_floor = last;
         m_dir   = (last == 0) ? 1'b1 : (last == 2) ? 1'b0 : (any_behind ? !d : d);

         press(c);
         wait_idle("rand");
         chk("rand_floor", floor, m_floor);
         chk("rand_dir", dir_up, m_dir);
         chk("rand_leds_clear", {rd_led, nd_led, st_led}, 0);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
